// File: rtl/uart_pkg.sv
// Shared state encoding, frame constants and helpers for the oversampled UART receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE  = ST_IDLE,
    RX_START = ST_START,
    RX_DATA  = ST_DATA,
    RX_STOP  = ST_STOP,
    RX_BREAK = ST_BREAK
  } rx_state_e;

  function automatic int calc_tick_div(input int clock_rate, input int baud_rate,
                                       input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

  function automatic bit tick_cfg_ok(input int clock_rate, input int baud_rate,
                                     input int oversample);
    return (oversample >= 8) && ((oversample % 2) == 0) &&
           (calc_tick_div(clock_rate, baud_rate, oversample) >= 2);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receive-side bundle between the serial line front end and the host logic.
interface uart_rx_oversampled_if;
  logic       rxEn;
  logic       rxIn;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;

  modport master (output rxEn, output rxIn,
                  input rxBusy, input rxDone, input rxErr, input rxOut);
  modport slave  (input rxEn, input rxIn,
                  output rxBusy, output rxDone, output rxErr, output rxOut);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample strobe generator: one-clk tick every TICK_DIV clocks, realigned by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  if (!tick_cfg_ok(CLOCK_RATE, BAUD_RATE, OVERSAMPLE)) begin : g_cfg_err
    $error("uart_baud_tick: need TICK_DIV >= 2 and an even OVERSAMPLE >= 8");
  end

  logic [DIV_W-1:0] div_q, div_d;

  // Next divider value: wraps at DIV_MAX, forced to zero on restart.
  always_comb begin
    if (restart || (div_q == DIV_MAX)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, LSB first, 16x oversampled with 2-of-3 mid-bit voting and framing checks.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_oversampled_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_nx_s;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 tick_s, restart_s, fall_s, vote_now_s, vote_s;

  uart_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart_s),
    .tick   (tick_s)
  );

  // Two-flop synchronizer plus edge-detect flop; idle-high preset avoids a false edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rxIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_s     = prev_q & ~sync2_q;
  assign cnt_nx_s   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  assign vote_now_s = tick_s && (cnt_nx_s == VOTE_C);
  assign vote_s     = majority3(v0_q, v1_q, sync2_q);

  // Receive FSM: sample counter, vote capture, shift register and output pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    busy_d    = busy_q;
    out_d     = out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    restart_s = 1'b0;
    if (!bus.rxEn) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      if (tick_s) begin
        cnt_d = cnt_nx_s;
        if (cnt_nx_s == VOTE_A) begin
          v0_d = sync2_q;
        end else if (cnt_nx_s == VOTE_B) begin
          v1_d = sync2_q;
        end else begin
          v0_d = v0_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (fall_s) begin
            state_d   = ST_START;
            busy_d    = 1'b1;
            restart_s = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (vote_now_s) begin
            if (vote_s) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
            end
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (vote_now_s) begin
            shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_STOP: begin
          if (vote_now_s) begin
            busy_d = 1'b0;
            if (vote_s) begin
              out_d   = shreg_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_BREAK;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_STOP;
          end
        end
        ST_BREAK: begin
          // Any low sample restarts the one-bit-time high qualification.
          if (!sync2_q) begin
            cnt_d = '0;
          end else if (tick_s) begin
            if (cnt_q == CNT_MAX) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign bus.rxBusy = busy_q;
  assign bus.rxDone = done_q;
  assign bus.rxErr  = err_q;
  assign bus.rxOut  = out_q;

endmodule
